// File: rtl/a5_pkg.sv
// a5_pkg: shared definitions for the A5/1-style keystream generator.
//   - a5_state_e : FSM state encoding (3 bits)
//   - default register lengths, feedback tap masks and clocking-bit indices
//   - a5_majority(): majority vote of three clock bits
//   - a5_max()    : integer max, used to size the shared phase counter
package a5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_KEY   = 3'd1,
        ST_LOAD_FRAME = 3'd2,
        ST_WARMUP     = 3'd3,
        ST_STREAM     = 3'd4,
        ST_DONE       = 3'd5
    } a5_state_e;

    localparam int A5_KEYLEN      = 64;
    localparam int A5_FRAMENUMLEN = 22;
    localparam int A5_R1LEN       = 19;
    localparam int A5_R2LEN       = 22;
    localparam int A5_R3LEN       = 23;
    localparam logic [A5_R1LEN-1:0] A5_R1TAPS = 19'h72000;
    localparam logic [A5_R2LEN-1:0] A5_R2TAPS = 22'h300000;
    localparam logic [A5_R3LEN-1:0] A5_R3TAPS = 23'h700080;
    localparam int A5_R1CLK       = 8;
    localparam int A5_R2CLK       = 10;
    localparam int A5_R3CLK       = 10;
    localparam int A5_WARMUP      = 100;
    localparam int A5_OUTLEN      = 228;

    function automatic logic a5_majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int a5_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/a5_lfsr_stage.sv
// a5_lfsr_stage: one Fibonacci-style LFSR of the keystream generator.
// Each step shifts left by one; the new bit0 is the parity of the tapped
// bits XOR the inject bit.  clear has priority over step.
// Ports:
//   clock, reset  - clock, asynchronous active-high reset
//   clear         - synchronous clear to all-zero
//   step          - advance the register by one position
//   inject        - bit folded into the feedback (0 outside the load phases)
//   msb           - register MSB (contributes to the keystream bit)
//   clkbit        - bit CLKBIT (input to the majority vote)
//   state         - full register contents
module a5_lfsr_stage #(
    parameter int           LEN    = 19,
    parameter logic [LEN-1:0] TAPS = '0,
    parameter int           CLKBIT = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           step,
    input  logic           inject,
    output logic           msb,
    output logic           clkbit,
    output logic [LEN-1:0] state
);

    logic [LEN-1:0] state_q;
    logic [LEN-1:0] state_d;

    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (clear) begin
            state_d = '0;
        end else if (step) begin
            state_d = {state_q[LEN-2:0], (^(state_q & TAPS)) ^ inject};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign msb    = state_q[LEN-1];
    assign clkbit = state_q[CLKBIT];
    assign state  = state_q;

endmodule

// File: rtl/a5_keystream_gen.sv
// a5_keystream_gen: A5/1-style keystream generator.
// Three LFSRs are cleared, loaded with the session key (LSB first) and the
// frame number (LSB first) under regular clocking, warmed up for WARMUP
// majority-clocked steps, then emit OUTLEN keystream bits through a
// valid/ready handshake.  done pulses for one cycle after the last bit.
// Ports:
//   clock, reset        - clock, asynchronous active-high reset
//   start               - request, sampled only in IDLE
//   key, frame          - captured on an accepted start
//   busy                - high in every state except IDLE
//   ks_valid/ks_ready   - keystream handshake; ks_bit valid while ks_valid
//   done                - one-cycle completion pulse
// Optional (macro A5_DEBUG_STATE_EN):
//   dbg_state           - {R3,R2,R1} register contents
//   dbg_phase           - FSM state code
module a5_keystream_gen
    import a5_pkg::*;
#(
    parameter int KEYLEN      = A5_KEYLEN,
    parameter int FRAMENUMLEN = A5_FRAMENUMLEN,
    parameter int R1LEN       = A5_R1LEN,
    parameter int R2LEN       = A5_R2LEN,
    parameter int R3LEN       = A5_R3LEN,
    parameter logic [R1LEN-1:0] R1TAPS = R1LEN'(A5_R1TAPS),
    parameter logic [R2LEN-1:0] R2TAPS = R2LEN'(A5_R2TAPS),
    parameter logic [R3LEN-1:0] R3TAPS = R3LEN'(A5_R3TAPS),
    parameter int R1CLK       = A5_R1CLK,
    parameter int R2CLK       = A5_R2CLK,
    parameter int R3CLK       = A5_R3CLK,
    parameter int WARMUP      = A5_WARMUP,
    parameter int OUTLEN      = A5_OUTLEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEYLEN-1:0]      key,
    input  logic [FRAMENUMLEN-1:0] frame,
    output logic                   busy,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic                   ks_bit,
    output logic                   done
`ifdef A5_DEBUG_STATE_EN
    ,
    output logic [R1LEN+R2LEN+R3LEN-1:0] dbg_state,
    output logic [2:0]                   dbg_phase
`endif
);

    localparam int CNT_W =
        $clog2(a5_max(a5_max(KEYLEN, FRAMENUMLEN), a5_max(WARMUP, OUTLEN)) + 1);

    a5_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [KEYLEN-1:0]      key_q, key_d;
    logic [FRAMENUMLEN-1:0] frame_q, frame_d;

    logic clear, step_all, step_maj, inject;
    logic key_bit, frame_bit, maj;
    logic r1_msb, r2_msb, r3_msb;
    logic r1_clk, r2_clk, r3_clk;
    logic r1_step, r2_step, r3_step;

    // Bit cnt of the shadows, as a mask so the counter width need not match
    // the index width of either shadow.
    assign key_bit   = |(key_q   & (KEYLEN'(1)      << cnt_q));
    assign frame_bit = |(frame_q & (FRAMENUMLEN'(1) << cnt_q));

    assign maj     = a5_majority(r1_clk, r2_clk, r3_clk);
    assign r1_step = step_all | (step_maj & (r1_clk == maj));
    assign r2_step = step_all | (step_maj & (r2_clk == maj));
    assign r3_step = step_all | (step_maj & (r3_clk == maj));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        frame_d  = frame_q;
        clear    = 1'b0;
        step_all = 1'b0;
        step_maj = 1'b0;
        inject   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    frame_d = frame;
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LOAD_KEY;
                end
            end
            ST_LOAD_KEY: begin
                step_all = 1'b1;
                inject   = key_bit;
                if (cnt_q == CNT_W'(KEYLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD_FRAME: begin
                step_all = 1'b1;
                inject   = frame_bit;
                if (cnt_q == CNT_W'(FRAMENUMLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = (WARMUP == 0) ? ST_STREAM : ST_WARMUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WARMUP: begin
                step_maj = 1'b1;
                if (cnt_q == CNT_W'(WARMUP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STREAM: begin
                // A stalled consumer freezes registers and count, so ks_bit holds.
                if (ks_ready) begin
                    step_maj = 1'b1;
                    if (cnt_q == CNT_W'(OUTLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            frame_q <= frame_d;
        end
    end

`ifdef A5_DEBUG_STATE_EN
    logic [R1LEN-1:0] r1_state;
    logic [R2LEN-1:0] r2_state;
    logic [R3LEN-1:0] r3_state;
`endif

    a5_lfsr_stage #(.LEN(R1LEN), .TAPS(R1TAPS), .CLKBIT(R1CLK)) u_r1 (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .step   (r1_step),
        .inject (inject),
        .msb    (r1_msb),
        .clkbit (r1_clk),
`ifdef A5_DEBUG_STATE_EN
        .state  (r1_state)
`else
        .state  ()
`endif
    );

    a5_lfsr_stage #(.LEN(R2LEN), .TAPS(R2TAPS), .CLKBIT(R2CLK)) u_r2 (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .step   (r2_step),
        .inject (inject),
        .msb    (r2_msb),
        .clkbit (r2_clk),
`ifdef A5_DEBUG_STATE_EN
        .state  (r2_state)
`else
        .state  ()
`endif
    );

    a5_lfsr_stage #(.LEN(R3LEN), .TAPS(R3TAPS), .CLKBIT(R3CLK)) u_r3 (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .step   (r3_step),
        .inject (inject),
        .msb    (r3_msb),
        .clkbit (r3_clk),
`ifdef A5_DEBUG_STATE_EN
        .state  (r3_state)
`else
        .state  ()
`endif
    );

    assign busy     = (state_q != ST_IDLE);
    assign ks_valid = (state_q == ST_STREAM);
    assign done     = (state_q == ST_DONE);
    // Gated so ks_bit reads 0 whenever no bit is being offered.
    assign ks_bit   = ks_valid & (r1_msb ^ r2_msb ^ r3_msb);

`ifdef A5_DEBUG_STATE_EN
    assign dbg_state = {r3_state, r2_state, r1_state};
    assign dbg_phase = state_q;
`endif

endmodule

// File: tb/tb_a5_keystream_gen.sv
// tb_a5_keystream_gen: randomized self-checking bench for a5_keystream_gen.
// A default-parameter instance and a WARMUP=0/OUTLEN=4 instance share the
// stimulus; sel chooses which one is driven and observed.  Expected bits
// come from a sequence-level model of the cipher kept in this file.
module tb_a5_keystream_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        ks_ready;
    logic        sel;

    logic start1, busy1, ks_valid1, ks_bit1, done1;
    logic start2, busy2, ks_valid2, ks_bit2, done2;
    logic s_busy, s_valid, s_bit, s_done;

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];

    localparam int             LENS[3]   = '{19, 22, 23};
    localparam int             CLKB[3]   = '{8, 10, 10};
    localparam logic [22:0]    TAPS_M[3] = '{23'h72000, 23'h300000, 23'h700080};

    always #5 clock = ~clock;

    assign start1  = start & ~sel;
    assign start2  = start & sel;
    assign s_busy  = sel ? busy2     : busy1;
    assign s_valid = sel ? ks_valid2 : ks_valid1;
    assign s_bit   = sel ? ks_bit2   : ks_bit1;
    assign s_done  = sel ? done2     : done1;

`ifdef A5_DEBUG_STATE_EN
    logic [63:0] dbg_state1, dbg_state2;
    logic [2:0]  dbg_phase1, dbg_phase2;
`endif

    a5_keystream_gen u_dut1 (
        .clock    (clock),
        .reset    (reset),
        .start    (start1),
        .key      (key),
        .frame    (frame),
        .busy     (busy1),
        .ks_valid (ks_valid1),
        .ks_ready (ks_ready),
        .ks_bit   (ks_bit1),
        .done     (done1)
`ifdef A5_DEBUG_STATE_EN
        ,
        .dbg_state (dbg_state1),
        .dbg_phase (dbg_phase1)
`endif
    );

    a5_keystream_gen #(.WARMUP(0), .OUTLEN(4)) u_dut2 (
        .clock    (clock),
        .reset    (reset),
        .start    (start2),
        .key      (key),
        .frame    (frame),
        .busy     (busy2),
        .ks_valid (ks_valid2),
        .ks_ready (ks_ready),
        .ks_bit   (ks_bit2),
        .done     (done2)
`ifdef A5_DEBUG_STATE_EN
        ,
        .dbg_state (dbg_state2),
        .dbg_phase (dbg_phase2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One register advance: shift in parity(tapped bits) ^ inj, keep LENS[j] bits.
    function automatic logic [22:0] mstep(input logic [22:0] v, input int j, input bit inj);
        logic [22:0] n;
        n = {v[21:0], (^(v & TAPS_M[j])) ^ inj};
        for (int b = LENS[j]; b < 23; b++) n[b] = 1'b0;
        return n;
    endfunction

    // Whole-frame keystream: load key and frame, warm up, then record one
    // output bit before each majority step.
    task automatic model_run(input logic [63:0] k, input logic [21:0] f,
                             input int warm, input int outl);
        logic [22:0] r[3];
        int votes;
        bit maj;
        exp_q.delete();
        for (int j = 0; j < 3; j++) r[j] = '0;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 3; j++) r[j] = mstep(r[j], j, k[i]);
        for (int i = 0; i < 22; i++)
            for (int j = 0; j < 3; j++) r[j] = mstep(r[j], j, f[i]);
        for (int i = 0; i < warm + outl; i++) begin
            if (i >= warm)
                exp_q.push_back(r[0][LENS[0]-1] ^ r[1][LENS[1]-1] ^ r[2][LENS[2]-1]);
            votes = 0;
            for (int j = 0; j < 3; j++) votes += int'(r[j][CLKB[j]]);
            maj = (votes >= 2);
            for (int j = 0; j < 3; j++)
                if (r[j][CLKB[j]] == maj) r[j] = mstep(r[j], j, 1'b0);
        end
    endtask

    // Runs one frame on the selected instance and checks it against exp_q.
    // Cycle 0 is the cycle in which start is held high.
    task automatic run_frame(input logic [63:0] k, input logic [21:0] f, input bit rnd,
                             input int exp_lat, input int repulse_cyc,
                             input int abort_bit, input int outl);
        int   cyc;
        int   got;
        bit   prev_stall;
        logic prev_bit;
        @(posedge clock); #1;
        key = k; frame = f; start = 1'b1; ks_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0; cyc = 1;
        check("busy_after_start", s_busy, 1);
        key = ~k; frame = ~f;
        while (!s_valid && cyc < 2000) begin
            if (cyc == repulse_cyc) begin
                start = 1'b1;
                key   = k ^ 64'h5A5A_A5A5_0F0F_F0F0;
            end
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
        end
        check("first_valid_cycle", cyc, exp_lat);
        got = 0; prev_stall = 1'b0; prev_bit = 1'b0;
        while (got < outl && cyc < 4000) begin
            if (!s_valid) begin
                check("valid_during_stream", s_valid, 1);
                break;
            end
            if (prev_stall) check("stall_hold", s_bit, prev_bit);
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ks_ready) begin
                check($sformatf("ks_bit[%0d]", got), s_bit, exp_q[got]);
                got++;
            end
            prev_stall = !ks_ready;
            prev_bit   = s_bit;
            if (abort_bit >= 0 && got == abort_bit) begin
                #2 reset = 1'b1;
                #1;
                check("abort_busy", s_busy, 0);
                check("abort_valid", s_valid, 0);
                check("abort_bit", s_bit, 0);
                check("abort_done", s_done, 0);
                @(posedge clock); #1;
                reset = 1'b0; ks_ready = 1'b0;
                return;
            end
            @(posedge clock); #1;
            cyc++;
        end
        ks_ready = 1'b0;
        check("bits_accepted", got, outl);
        if (!rnd) check("done_cycle", cyc, exp_lat + outl);
        check("done_pulse", s_done, 1);
        check("done_busy", s_busy, 1);
        check("done_valid", s_valid, 0);
        @(posedge clock); #1;
        check("done_one_cycle", s_done, 0);
        check("idle_busy", s_busy, 0);
    endtask

    initial begin
        logic [63:0] gk;
        logic [63:0] rk;
        logic [21:0] rf;
        reset = 1'b1; start = 1'b0; key = '0; frame = '0; ks_ready = 1'b0; sel = 1'b0;
        #23;
        check("reset_busy", busy1, 0);
        check("reset_valid", ks_valid1, 0);
        check("reset_bit", ks_bit1, 0);
        check("reset_done", done1, 0);
        check("reset_busy2", busy2, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // All-zero key and frame: zero keystream, done at cycle 415.
        model_run(64'h0, 22'h0, 100, 228);
        run_frame(64'h0, 22'h0, 1'b0, 187, -1, -1, 228);

        gk = 64'hEFCDAB8967452312;
        model_run(gk, 22'h134, 100, 228);
        run_frame(gk, 22'h134, 1'b0, 187, -1, -1, 228);
        run_frame(gk, 22'h134, 1'b1, 187, -1, -1, 228);
        run_frame(gk, 22'h134, 1'b0, 187, 50, -1, 228);
        run_frame(gk, 22'h134, 1'b1, 187, -1, 100, 228);
        run_frame(gk, 22'h134, 1'b0, 187, -1, -1, 228);

        for (int n = 0; n < 2; n++) begin
            rk = {$urandom, $urandom};
            rf = 22'($urandom);
            model_run(rk, rf, 100, 228);
            run_frame(rk, rf, 1'b1, 187, -1, -1, 228);
        end

        // WARMUP=0, OUTLEN=4 instance.
        sel = 1'b1;
        model_run(gk, 22'h134, 0, 4);
        run_frame(gk, 22'h134, 1'b0, 87, -1, -1, 4);
        rk = {$urandom, $urandom};
        rf = 22'($urandom);
        model_run(rk, rf, 0, 4);
        run_frame(rk, rf, 1'b1, 87, -1, -1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/a5_keystream_gen.md
Name: a5_keystream_gen

Overview:
- Complete A5/1-style keystream generator: three parametrised LFSRs with majority (stop/go) clocking.
- Sequences key load, frame-number load, warm-up and keystream output under an FSM.
- Successor to the single fixed LFSR stage: adds configurable lengths, taps and phase lengths, irregular clocking, and a valid/ready output handshake.
- Sits between the key/frame source and the burst XOR/cipher datapath.

Parameters:
- KEYLEN, 64, session key width in bits.
- FRAMENUMLEN, 22, frame number width in bits.
- R1LEN / R2LEN / R3LEN, 19 / 22 / 23, LFSR lengths.
- R1TAPS / R2TAPS / R3TAPS, 'h72000 / 'h300000 / 'h700080, feedback tap masks (bit i set = bit i tapped).
- R1CLK / R2CLK / R3CLK, 8 / 10 / 10, clocking-bit index per LFSR.
- WARMUP, 100, number of discarded majority-clocked cycles.
- OUTLEN, 228, keystream bits per frame.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- key  in  KEYLEN  session key; captured on accepted start.
- frame  in  FRAMENUMLEN  frame number; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- ks_valid  out  1  keystream bit available.
- ks_ready  in  1  consumer accepts bit.
- ks_bit  out  1  keystream bit; meaningful only while ks_valid is high.
- done  out  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (asynchronous): FSM=IDLE; all LFSRs, counters, key/frame shadows=0; busy=ks_valid=done=ks_bit=0.
- LFSR step: shift left by 1; new bit0 = XOR of bits selected by TAPS, XOR the inject bit. Inject is 0 outside the load states. No inversion.
- Output bit: XOR of the three MSBs.
- IDLE: start=1 captures key/frame into shadows, clears all LFSRs, clears counter, enters LOAD_KEY next cycle.
- LOAD_KEY, KEYLEN cycles: all three LFSRs step every cycle and inject key[cnt]. key[0] is injected first.
- LOAD_FRAME, FRAMENUMLEN cycles: same regular stepping, injecting frame[cnt] (LSB first).
- WARMUP, WARMUP cycles:
  - maj = majority of the three clock bits.
  - Each LFSR whose clock bit equals maj steps; the others hold.
  - Output is discarded; ks_valid=0.
- STREAM:
  - ks_valid=1; ks_bit = output bit of the current state, which is combinational from the registers.
  - On ks_valid & ks_ready: one majority step, count+1.
  - ks_ready=0 stalls: no step; ks_bit and count held.
  - After OUTLEN accepted bits, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency: start to first ks_valid = 1 + KEYLEN + FRAMENUMLEN + WARMUP cycles (187 at defaults).
- Phase counter: one shared counter, width $clog2(max(KEYLEN, FRAMENUMLEN, WARMUP, OUTLEN)+1). It resets to 0 on every phase transition, and the transition fires when count reaches phase length − 1 with the step taken.
- Boundaries:
  - start while busy is ignored; no restart and no capture.
  - key/frame changes after capture have no effect.
  - reset mid-phase aborts immediately to IDLE; the next start reloads from scratch.
  - start asserted in the same cycle as done: ignored (FSM not in IDLE).
  - WARMUP=0 skips straight to STREAM.
  - All-zero key and frame leaves the LFSRs at 0; legal, and the keystream is all zeros.

Optional Feature:
- Macro: A5_DEBUG_STATE_EN.
- Defined: adds output dbg_state [R1LEN+R2LEN+R3LEN], equal to {R3,R2,R1} registered contents, and output dbg_phase [2:0], the FSM state code. Both are 0 in reset.
- Undefined: neither port exists; functionality is otherwise identical.

Decomposition:
- Package a5_pkg:
  - FSM state enum (IDLE, LOAD_KEY, LOAD_FRAME, WARMUP, STREAM, DONE) with a 3-bit encoding.
  - Default length, tap and clock-bit constants.
  - A majority function.
- Sub-module a5_lfsr_stage, instantiated three times:
  - Parameters LEN, TAPS, CLKBIT.
  - Inputs: clock, reset, clear, step, inject.
  - Outputs: msb, clkbit, state.

Test Plan:
- All-zero key=0, frame=0, ks_ready=1 → ks_valid rises 187 cycles after start; 228 bits all 0; done pulses once at cycle 415; busy drops the next cycle.
- key=64'hEFCDAB8967452312, frame=22'h134 → 228-bit stream matches the team golden C model bit for bit; the first 8 bits are checked explicitly against the model dump.
- Same as the previous case, with ks_ready toggled pseudo-randomly (50%) → identical bit sequence; ks_bit stable while ks_valid & !ks_ready.
- start re-pulsed at cycle 50 with a different key → ignored; output equals the first-key run.
- reset asserted at stream bit 100 → all outputs 0 asynchronously. A new start then gives the full stream from bit 0, identical to a clean run.
- Parameter override WARMUP=0, OUTLEN=4 → ks_valid at cycle 87 after start; exactly 4 bits; done at the 5th cycle of streaming with ready=1.
